id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the 5-stage pipelined CPU. Sits directly downstream of the instruction decoder.
- Registers the decoder control word plus ID-stage operands into the EX stage.
- Contains the load-use hazard detector: on a hazard it stalls PC and IF/ID and inserts a bubble.
- Takes a flush from branch/jump resolution and squashes the instruction entering EX.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage CPU with the load-use
// hazard detector. On a load-use hazard it stalls PC and IF/ID and inserts a
// bubble into EX; a branch/jump flush squashes the instruction entering EX
// and takes priority over the stall.
// Optional build macro: ID_EX_STALL_CNT_EN adds a saturating 32-bit stall
// counter on stall_cnt_o. Without it the port and counter do not exist.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_regwrite_i,
    input  logic [2:0]        id_aluop_i,
    input  logic              id_alusrc_i,
    input  logic              id_regdst_i,
    input  logic              id_branch_i,
    input  logic              id_memtoreg_i,
    input  logic              id_memwrite_i,
    input  logic              id_memread_i,
    input  logic              id_jump_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [DATA_W-1:0] id_rsdata_i,
    input  logic [DATA_W-1:0] id_rtdata_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [5:0]        id_funct_i,
    input  logic              flush_i,
    output logic              ex_regwrite_o,
    output logic [2:0]        ex_aluop_o,
    output logic              ex_alusrc_o,
    output logic              ex_regdst_o,
    output logic              ex_branch_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memwrite_o,
    output logic              ex_memread_o,
    output logic              ex_jump_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [DATA_W-1:0] ex_rsdata_o,
    output logic [DATA_W-1:0] ex_rtdata_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [5:0]        ex_funct_o,
    output logic              ex_valid_o,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              stall_o
);

    logic hazard;
    logic loadEn;

    // Load-use detection against the load sitting in EX; a bubble has rt=0
    // and valid=0, so it can never raise a hazard.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hazard = 1'b0;
        if (ex_memread_o && ex_valid_o && (ex_rt_o != '0) &&
            ((ex_rt_o == id_rs_i) || (ex_rt_o == id_rt_i))) begin
            hazard = 1'b1;
        end
    end

    // A flushed instruction is discarded anyway, so holding PC/IF-ID for it
    // would only waste a cycle: flush masks the stall.
    assign stall_o = hazard & ~flush_i;
    assign loadEn  = ~flush_i & ~hazard;

    // Pipeline register: load the ID instruction, or an all-zero bubble on
    // flush or hazard.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_regwrite_o <= 1'b0;
            ex_aluop_o    <= '0;
            ex_alusrc_o   <= 1'b0;
            ex_regdst_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_jump_o     <= 1'b0;
            ex_pc4_o      <= '0;
            ex_rsdata_o   <= '0;
            ex_rtdata_o   <= '0;
            ex_imm_o      <= '0;
            ex_rs_o       <= '0;
            ex_rt_o       <= '0;
            ex_rd_o       <= '0;
            ex_funct_o    <= '0;
            ex_valid_o    <= 1'b0;
        end else begin
            ex_regwrite_o <= loadEn & id_regwrite_i;
            ex_aluop_o    <= loadEn ? id_aluop_i  : '0;
            ex_alusrc_o   <= loadEn & id_alusrc_i;
            ex_regdst_o   <= loadEn & id_regdst_i;
            ex_branch_o   <= loadEn & id_branch_i;
            ex_memtoreg_o <= loadEn & id_memtoreg_i;
            ex_memwrite_o <= loadEn & id_memwrite_i;
            ex_memread_o  <= loadEn & id_memread_i;
            ex_jump_o     <= loadEn & id_jump_i;
            ex_pc4_o      <= loadEn ? id_pc4_i    : '0;
            ex_rsdata_o   <= loadEn ? id_rsdata_i : '0;
            ex_rtdata_o   <= loadEn ? id_rtdata_i : '0;
            ex_imm_o      <= loadEn ? id_imm_i    : '0;
            ex_rs_o       <= loadEn ? id_rs_i     : '0;
            ex_rt_o       <= loadEn ? id_rt_i     : '0;
            ex_rd_o       <= loadEn ? id_rd_i     : '0;
            ex_funct_o    <= loadEn ? id_funct_i  : '0;
            ex_valid_o    <= loadEn;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Count stall cycles, saturating at all-ones; flush cycles never stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage. Covers reset, pass-through,
// load-use stall, back-to-back loads, $0 exemption, flush priority and reset
// asserted mid-stall; counter checks compile in with ID_EX_STALL_CNT_EN.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              id_regwrite_i;
    logic [2:0]        id_aluop_i;
    logic              id_alusrc_i;
    logic              id_regdst_i;
    logic              id_branch_i;
    logic              id_memtoreg_i;
    logic              id_memwrite_i;
    logic              id_memread_i;
    logic              id_jump_i;
    logic [DATA_W-1:0] id_pc4_i;
    logic [DATA_W-1:0] id_rsdata_i;
    logic [DATA_W-1:0] id_rtdata_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic [5:0]        id_funct_i;
    logic              flush_i;
    logic              ex_regwrite_o;
    logic [2:0]        ex_aluop_o;
    logic              ex_alusrc_o;
    logic              ex_regdst_o;
    logic              ex_branch_o;
    logic              ex_memtoreg_o;
    logic              ex_memwrite_o;
    logic              ex_memread_o;
    logic              ex_jump_o;
    logic [DATA_W-1:0] ex_pc4_o;
    logic [DATA_W-1:0] ex_rsdata_o;
    logic [DATA_W-1:0] ex_rtdata_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [REG_AW-1:0] ex_rs_o;
    logic [REG_AW-1:0] ex_rt_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic [5:0]        ex_funct_o;
    logic              ex_valid_o;
    logic              stall_o;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]       stall_cnt_o;
`endif

    int passCount  = 0;
    int checkCount = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_regwrite_i(id_regwrite_i), .id_aluop_i(id_aluop_i),
        .id_alusrc_i(id_alusrc_i), .id_regdst_i(id_regdst_i),
        .id_branch_i(id_branch_i), .id_memtoreg_i(id_memtoreg_i),
        .id_memwrite_i(id_memwrite_i), .id_memread_i(id_memread_i),
        .id_jump_i(id_jump_i), .id_pc4_i(id_pc4_i),
        .id_rsdata_i(id_rsdata_i), .id_rtdata_i(id_rtdata_i),
        .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rd_i(id_rd_i), .id_funct_i(id_funct_i), .flush_i(flush_i),
        .ex_regwrite_o(ex_regwrite_o), .ex_aluop_o(ex_aluop_o),
        .ex_alusrc_o(ex_alusrc_o), .ex_regdst_o(ex_regdst_o),
        .ex_branch_o(ex_branch_o), .ex_memtoreg_o(ex_memtoreg_o),
        .ex_memwrite_o(ex_memwrite_o), .ex_memread_o(ex_memread_o),
        .ex_jump_o(ex_jump_o), .ex_pc4_o(ex_pc4_o),
        .ex_rsdata_o(ex_rsdata_o), .ex_rtdata_o(ex_rtdata_o),
        .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
        .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o), .ex_valid_o(ex_valid_o),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive a NOP (all zero) into ID.
    task automatic clearId();
        id_regwrite_i = 0; id_aluop_i = 3'b000; id_alusrc_i = 0; id_regdst_i = 0;
        id_branch_i = 0; id_memtoreg_i = 0; id_memwrite_i = 0; id_memread_i = 0;
        id_jump_i = 0; id_pc4_i = '0; id_rsdata_i = '0; id_rtdata_i = '0;
        id_imm_i = '0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0; id_funct_i = '0;
    endtask

    task automatic setLoad(input logic [4:0] rs, input logic [4:0] rt);
        clearId();
        id_regwrite_i = 1; id_alusrc_i = 1; id_memtoreg_i = 1; id_memread_i = 1;
        id_rs_i = rs; id_rt_i = rt; id_imm_i = 32'd4; id_pc4_i = 32'h200;
    endtask

    task automatic setAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clearId();
        id_regwrite_i = 1; id_aluop_i = 3'b100; id_regdst_i = 1;
        id_rs_i = rs; id_rt_i = rt; id_rd_i = rd; id_funct_i = 6'h20;
    endtask

    // Advance one rising edge, land on the following falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        // ---- Reset with nonzero ID inputs ----
        rst_i = 1'b1; flush_i = 1'b0;
        setAdd(5'd3, 5'd4, 5'd5);
        id_rsdata_i = 32'hDEAD; id_memread_i = 1;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid", 32'(ex_valid_o), 32'd0);
        check("rst_regwrite", 32'(ex_regwrite_o), 32'd0);
        check("rst_rsdata", ex_rsdata_o, 32'd0);
        check("rst_rd", 32'(ex_rd_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        check("rst_cnt", stall_cnt_o, 32'd0);
`endif
        step();
        check("rst_hold_valid", 32'(ex_valid_o), 32'd0);
        rst_i = 1'b1;

        // ---- Pass-through R-type ----
        setAdd(5'd8, 5'd9, 5'd10);
        id_rsdata_i = 32'h11; id_rtdata_i = 32'h22;
        id_imm_i = 32'h1234; id_pc4_i = 32'h100;
        step();
        check("pt_valid", 32'(ex_valid_o), 32'd1);
        check("pt_regwrite", 32'(ex_regwrite_o), 32'd1);
        check("pt_aluop", 32'(ex_aluop_o), 32'd4);
        check("pt_regdst", 32'(ex_regdst_o), 32'd1);
        check("pt_rs", 32'(ex_rs_o), 32'd8);
        check("pt_rt", 32'(ex_rt_o), 32'd9);
        check("pt_rd", 32'(ex_rd_o), 32'd10);
        check("pt_rsdata", ex_rsdata_o, 32'h11);
        check("pt_rtdata", ex_rtdata_o, 32'h22);
        check("pt_imm", ex_imm_o, 32'h1234);
        check("pt_pc4", ex_pc4_o, 32'h100);
        check("pt_funct", 32'(ex_funct_o), 32'h20);
        check("pt_memread", 32'(ex_memread_o), 32'd0);

        // ---- Load-use stall: lw rt=8, then add rs=8 ----
        setLoad(5'd1, 5'd8);
        #1 check("lu_nostall_pre", 32'(stall_o), 32'd0);
        step();
        check("lu_lw_in_ex_memread", 32'(ex_memread_o), 32'd1);
        check("lu_lw_in_ex_rt", 32'(ex_rt_o), 32'd8);
        setAdd(5'd8, 5'd2, 5'd3);
        #1 check("lu_stall", 32'(stall_o), 32'd1);
        step();
        check("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
        check("lu_bubble_rt", 32'(ex_rt_o), 32'd0);
        check("lu_bubble_regwrite", 32'(ex_regwrite_o), 32'd0);
        check("lu_bubble_alusrc", 32'(ex_alusrc_o), 32'd0);
        check("lu_stall_drop", 32'(stall_o), 32'd0);
        step();
        check("lu_add_valid", 32'(ex_valid_o), 32'd1);
        check("lu_add_rs", 32'(ex_rs_o), 32'd8);
        check("lu_add_rd", 32'(ex_rd_o), 32'd3);

        // ---- Back-to-back dependent loads ----
        setLoad(5'd1, 5'd9);
        step();
        setLoad(5'd9, 5'd10);
        #1 check("bb_stall1", 32'(stall_o), 32'd1);
        step();
        check("bb_bubble1", 32'(ex_valid_o), 32'd0);
        check("bb_nostall1", 32'(stall_o), 32'd0);
        step();
        check("bb_lw2_rt", 32'(ex_rt_o), 32'd10);
        check("bb_lw2_rs", 32'(ex_rs_o), 32'd9);
        setAdd(5'd11, 5'd10, 5'd12);
        #1 check("bb_stall2", 32'(stall_o), 32'd1);
        step();
        check("bb_bubble2", 32'(ex_valid_o), 32'd0);
        step();
        check("bb_add_rd", 32'(ex_rd_o), 32'd12);
        check("bb_add_valid", 32'(ex_valid_o), 32'd1);

        // ---- $0 exemption ----
        setLoad(5'd1, 5'd0);
        step();
        check("z_lw_valid", 32'(ex_valid_o), 32'd1);
        check("z_lw_memread", 32'(ex_memread_o), 32'd1);
        setAdd(5'd0, 5'd0, 5'd4);
        #1 check("z_nostall", 32'(stall_o), 32'd0);
        step();
        check("z_add_rd", 32'(ex_rd_o), 32'd4);

        // ---- Flush beats stall ----
        setLoad(5'd1, 5'd5);
        step();
        setAdd(5'd5, 5'd6, 5'd7);
        #1 check("fl_hazard", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        #1 check("fl_stall_masked", 32'(stall_o), 32'd0);
        step();
        check("fl_bubble_valid", 32'(ex_valid_o), 32'd0);
        check("fl_bubble_rd", 32'(ex_rd_o), 32'd0);
        flush_i = 1'b0;
        clearId();
        id_rd_i = 5'd1;
        step();
        check("fl_next_valid", 32'(ex_valid_o), 32'd1);
        check("fl_next_rd", 32'(ex_rd_o), 32'd1);
`ifdef ID_EX_STALL_CNT_EN
        check("cnt_three", stall_cnt_o, 32'd3);
`endif

        // ---- Reset asserted mid-stall ----
        setLoad(5'd1, 5'd6);
        step();
        setAdd(5'd6, 5'd2, 5'd13);
        #1 check("ms_stall", 32'(stall_o), 32'd1);
        #1 rst_i = 1'b0;
        #1;
        check("ms_stall_drop", 32'(stall_o), 32'd0);
        check("ms_valid", 32'(ex_valid_o), 32'd0);
        check("ms_memread", 32'(ex_memread_o), 32'd0);
        check("ms_rt", 32'(ex_rt_o), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        check("ms_cnt", stall_cnt_o, 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        check("ms_restart_valid", 32'(ex_valid_o), 32'd1);
        check("ms_restart_rd", 32'(ex_rd_o), 32'd13);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
